// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples the SPI pins on FastClk, decodes a command byte,
// then runs an auto-incrementing burst of register writes or prefetched reads.
module spi_target #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  FastClk,
  input  logic                  Reset,
  input  logic                  TgtClk,
  input  logic                  TgtDi,
  input  logic                  nTgtSel,
  output logic                  TgtDo,
  output logic                  TgtDoEn,
  input  logic [7:0]            Status,
  output logic [ADDR_WIDTH-1:0] RegAddr,
  output logic [7:0]            RegWrData,
  output logic                  RegWrStrobe,
  output logic                  RegRdStrobe,
  input  logic [7:0]            RegRdData,
  output logic                  Busy
);

  typedef enum logic [2:0] {S_ABORT, S_IDLE, S_CMD, S_WRITE, S_READ} state_t;

  state_t                  r_state, w_next;
  logic [SYNC_STAGES-1:0]  r_sck_sync, r_di_sync, r_cs_sync;
  logic                    r_sck_d, r_cs_d;
  logic                    w_sck, w_di, w_cs;
  logic                    w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall;
  logic                    w_active, w_rise_ok, w_byte_done;
  logic [7:0]              w_byte;
  logic [2:0]              r_bitcnt;
  logic                    r_armed;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_wr_data;
  logic                    r_wr_stb, r_rd_stb, r_rd_pend, r_busy;
  logic [7:0]              r_rx, r_tx, r_hold;

  always_ff @(posedge FastClk) begin
    r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], TgtClk};
    r_di_sync  <= {r_di_sync[SYNC_STAGES-2:0], TgtDi};
    r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], nTgtSel};
    r_sck_d    <= w_sck;
    r_cs_d     <= w_cs;
  end

  assign w_sck = r_sck_sync[SYNC_STAGES-1];
  assign w_di  = r_di_sync[SYNC_STAGES-1];
  assign w_cs  = r_cs_sync[SYNC_STAGES-1];

  // Deselection wins over any SCK edge seen in the same cycle.
  assign w_cs_rise   = w_cs & ~r_cs_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_sck_rise  = w_sck & ~r_sck_d & ~w_cs_rise;
  assign w_sck_fall  = ~w_sck & r_sck_d & ~w_cs_rise;
  assign w_active    = (r_state == S_CMD) || (r_state == S_WRITE) || (r_state == S_READ);
  assign w_rise_ok   = w_sck_rise & r_armed & w_active;
  assign w_byte_done = w_rise_ok && (r_bitcnt == 3'd7);
  assign w_byte      = {r_rx[6:0], w_di};

  always_ff @(posedge FastClk) begin
    if (Reset) r_state <= S_ABORT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ABORT: if (w_cs) w_next = S_IDLE;
      S_IDLE:  if (w_cs_fall) w_next = S_CMD;
      S_CMD: begin
        if (w_cs_rise)        w_next = S_IDLE;
        else if (w_byte_done) w_next = w_byte[7] ? S_READ : S_WRITE;
      end
      S_WRITE, S_READ: if (w_cs_rise) w_next = S_IDLE;
      default: w_next = S_ABORT;
    endcase
  end

  always_comb begin
    TgtDoEn = 1'b0;
    TgtDo   = 1'b1;
    case (r_state)
      S_CMD, S_READ: begin
        TgtDoEn = 1'b1;
        TgtDo   = r_tx[7];
      end
      S_WRITE: begin
        TgtDoEn = 1'b1;
        TgtDo   = 1'b0;
      end
      default: ;
    endcase
  end

  // Control: bit counter, strobes, address pointer.
  always_ff @(posedge FastClk) begin
    if (Reset) begin
      r_bitcnt  <= 3'd0;
      r_armed   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= 8'h00;
      r_wr_stb  <= 1'b0;
      r_rd_stb  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_busy    <= ~w_cs;
      r_wr_stb  <= 1'b0;
      r_rd_stb  <= 1'b0;
      r_rd_pend <= r_rd_stb;
      if (r_rd_pend || r_wr_stb) r_addr <= r_addr + 1'b1;
      if (r_state == S_IDLE && w_cs_fall) begin
        r_bitcnt <= 3'd0;
        r_armed  <= ~w_sck;
      end else if (w_active) begin
        if (w_cs_rise) r_bitcnt <= 3'd0;
        if (w_sck_fall) r_armed <= 1'b1;
        if (w_rise_ok) r_bitcnt <= r_bitcnt + 3'd1;
        if (w_byte_done) begin
          case (r_state)
            S_CMD: begin
              r_addr   <= w_byte[ADDR_WIDTH-1:0];
              r_rd_stb <= w_byte[7];
            end
            S_WRITE: begin
              r_wr_data <= w_byte;
              r_wr_stb  <= 1'b1;
            end
            default: r_rd_stb <= 1'b1;
          endcase
        end
      end
    end
  end

  // Datapath: shift registers and read holding byte.
  always_ff @(posedge FastClk) begin
    if (r_rd_pend) r_hold <= RegRdData;
    if (r_state == S_IDLE && w_cs_fall) begin
      r_tx <= Status;
    end else if (w_sck_fall && r_armed) begin
      if (r_state == S_READ && r_bitcnt == 3'd0) r_tx <= r_hold;
      else                                        r_tx <= {r_tx[6:0], 1'b1};
    end
    if (w_rise_ok) r_rx <= w_byte;
  end

  assign RegAddr     = r_addr;
  assign RegWrData   = r_wr_data;
  assign RegWrStrobe = r_wr_stb;
  assign RegRdStrobe = r_rd_stb;
  assign Busy        = r_busy;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI initiator model at FastClk/8 plus a
// 128-byte register model that logs every write and read strobe.
module tb_spi_target;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       Reset, TgtClk, TgtDi, nTgtSel;
  logic       TgtDo, TgtDoEn, RegWrStrobe, RegRdStrobe, Busy;
  logic [7:0] Status, RegWrData;
  logic [7:0] RegRdData = 8'h00;
  logic [6:0] RegAddr;

  logic [7:0] mem [128];
  logic [6:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  logic [6:0] rd_addr_log [64];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic       both_seen = 1'b0;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] rx;
  int         base;

  always #5 clk = ~clk;

  spi_target #(.ADDR_WIDTH(7), .SYNC_STAGES(2)) dut (
    .FastClk    (clk),
    .Reset      (Reset),
    .TgtClk     (TgtClk),
    .TgtDi      (TgtDi),
    .nTgtSel    (nTgtSel),
    .TgtDo      (TgtDo),
    .TgtDoEn    (TgtDoEn),
    .Status     (Status),
    .RegAddr    (RegAddr),
    .RegWrData  (RegWrData),
    .RegWrStrobe(RegWrStrobe),
    .RegRdStrobe(RegRdStrobe),
    .RegRdData  (RegRdData),
    .Busy       (Busy)
  );

  // Register file model: read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else begin
      if (RegWrStrobe) begin
        mem[RegAddr]                <= RegWrData;
        wr_addr_log[wr_cnt[5:0]]    <= RegAddr;
        wr_data_log[wr_cnt[5:0]]    <= RegWrData;
        wr_cnt                      <= wr_cnt + 1;
      end
      if (RegRdStrobe) begin
        RegRdData                   <= mem[RegAddr];
        rd_addr_log[rd_cnt[5:0]]    <= RegAddr;
        rd_cnt                      <= rd_cnt + 1;
      end
      if (RegWrStrobe && RegRdStrobe) both_seen <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 0; i < n; i++) begin
      TgtDi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rxb[7-i] = TgtDo;
      TgtClk = 1'b1;
      repeat (HALF) @(negedge clk);
      TgtClk = 1'b0;
    end
  endtask

  task automatic cs_select();
    nTgtSel = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_release();
    repeat (HALF) @(negedge clk);
    nTgtSel = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    Reset = 1'b1; nTgtSel = 1'b0; TgtClk = 1'b0; TgtDi = 1'b0; Status = 8'h00;
    // Reset held while selected and SCK toggling.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      TgtClk = ~TgtClk;
    end
    TgtClk = 1'b0;
    @(negedge clk);
    chk("rst_do",    {7'd0, TgtDo},   8'h01);
    chk("rst_doen",  {7'd0, TgtDoEn}, 8'h00);
    chk("rst_addr",  {1'b0, RegAddr}, 8'h00);
    chk("rst_wdata", RegWrData,       8'h00);
    chk("rst_stb",   {6'd0, RegWrStrobe, RegRdStrobe}, 8'h00);
    chk("rst_busy",  {7'd0, Busy},    8'h00);
    Reset = 1'b0;
    // Transfer already in progress at reset release must be ignored.
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h42, 8, rx);
    chk("abort_doen", {7'd0, TgtDoEn}, 8'h00);
    chk("abort_wr",   8'(wr_cnt), 8'd0);
    chk("abort_rd",   8'(rd_cnt), 8'd0);
    cs_release();

    // Write burst at 0x05 with status 0xC3 returned on the command byte.
    Status = 8'hC3;
    cs_select();
    chk("sel_doen", {7'd0, TgtDoEn}, 8'h01);
    spi_bits(8'h05, 8, rx);
    chk("status_rx", rx, 8'hC3);
    spi_bits(8'h11, 8, rx);
    chk("write_miso", rx, 8'h00);
    spi_bits(8'h22, 8, rx);
    spi_bits(8'h33, 8, rx);
    cs_release();
    chk("wr3_cnt", 8'(wr_cnt), 8'd3);
    chk("wr0_addr", {1'b0, wr_addr_log[0]}, 8'h05);
    chk("wr0_data", wr_data_log[0], 8'h11);
    chk("wr1_addr", {1'b0, wr_addr_log[1]}, 8'h06);
    chk("wr1_data", wr_data_log[1], 8'h22);
    chk("wr2_addr", {1'b0, wr_addr_log[2]}, 8'h07);
    chk("wr2_data", wr_data_log[2], 8'h33);
    chk("addr_keep", {1'b0, RegAddr}, 8'h08);
    chk("desel_doen", {7'd0, TgtDoEn}, 8'h00);
    chk("desel_do",   {7'd0, TgtDo},   8'h01);

    // Read burst across the address wrap.
    base = rd_cnt;
    cs_select();
    spi_bits(8'hFE, 8, rx);
    spi_bits(8'h00, 8, rx);
    chk("rd_b0", rx, 8'h24);
    spi_bits(8'h00, 8, rx);
    chk("rd_b1", rx, 8'h25);
    spi_bits(8'h00, 8, rx);
    chk("rd_b2", rx, 8'h5A);
    cs_release();
    chk("rd_cnt", 8'(rd_cnt - base), 8'd4);
    chk("rd_a0", {1'b0, rd_addr_log[base]},     8'h7E);
    chk("rd_a1", {1'b0, rd_addr_log[base + 1]}, 8'h7F);
    chk("rd_a2", {1'b0, rd_addr_log[base + 2]}, 8'h00);
    chk("rd_a3", {1'b0, rd_addr_log[base + 3]}, 8'h01);

    // Partial byte is dropped; the next transfer is unaffected.
    cs_select();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'hFF, 5, rx);
    cs_release();
    chk("partial_wr", 8'(wr_cnt), 8'd3);
    cs_select();
    spi_bits(8'h10, 8, rx);
    spi_bits(8'hAA, 8, rx);
    cs_release();
    chk("after_partial_cnt", 8'(wr_cnt), 8'd4);
    chk("after_partial_addr", {1'b0, wr_addr_log[3]}, 8'h10);
    chk("after_partial_data", wr_data_log[3], 8'hAA);

    // Selected while SCK is high: the first falling edge is not counted.
    Status = 8'h96;
    TgtClk = 1'b1;
    repeat (8) @(negedge clk);
    nTgtSel = 1'b0;
    repeat (8) @(negedge clk);
    TgtClk = 1'b0;
    repeat (8) @(negedge clk);
    spi_bits(8'h20, 8, rx);
    chk("viol_status", rx, 8'h96);
    spi_bits(8'h77, 8, rx);
    cs_release();
    chk("viol_cnt",  8'(wr_cnt), 8'd5);
    chk("viol_addr", {1'b0, wr_addr_log[4]}, 8'h20);
    chk("viol_data", wr_data_log[4], 8'h77);

    // Busy lag and 4-byte write / read-back at 0x40.
    nTgtSel = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_lag_lo", {7'd0, Busy}, 8'h00);
    @(negedge clk);
    chk("busy_set", {7'd0, Busy}, 8'h01);
    repeat (5) @(negedge clk);
    spi_bits(8'h40, 8, rx);
    spi_bits(8'hA1, 8, rx);
    spi_bits(8'hB2, 8, rx);
    spi_bits(8'hC3, 8, rx);
    spi_bits(8'hD4, 8, rx);
    repeat (HALF) @(negedge clk);
    nTgtSel = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_lag_hi", {7'd0, Busy}, 8'h01);
    @(negedge clk);
    chk("busy_clr", {7'd0, Busy}, 8'h00);
    repeat (8) @(negedge clk);
    chk("wb_cnt", 8'(wr_cnt), 8'd9);
    cs_select();
    spi_bits(8'hC0, 8, rx);
    spi_bits(8'h00, 8, rx);
    chk("rb0", rx, 8'hA1);
    spi_bits(8'h00, 8, rx);
    chk("rb1", rx, 8'hB2);
    spi_bits(8'h00, 8, rx);
    chk("rb2", rx, 8'hC3);
    spi_bits(8'h00, 8, rx);
    chk("rb3", rx, 8'hD4);
    cs_release();
    chk("strobe_excl", {7'd0, both_seen}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 responder (target) that lets an external SPI initiator, such as the cartridge MCU or a test host, read and write an internal 8-bit register/buffer space.
- SPI pins are oversampled in the FastClk domain; the block decodes a command byte, then runs an auto-incrementing burst of register writes or reads.
- It is the peer end of the existing SPI initiator, and its register-side strobes connect to the same register file the swan bus uses.

Parameters:
- ADDR_WIDTH, 7, width of the address field in the command byte and of RegAddr.
- SYNC_STAGES, 2, synchroniser flops on TgtClk, TgtDi and nTgtSel (minimum 2).

Ports:
- FastClk  in  1  sole clock; all logic is rising-edge.
- Reset  in  1  synchronous, active-high.
- TgtClk  in  1  SPI SCK from the initiator (asynchronous).
- TgtDi  in  1  MOSI (asynchronous).
- nTgtSel  in  1  active-low chip select (asynchronous).
- TgtDo  out  1  MISO data.
- TgtDoEn  out  1  MISO output enable; the top level tristates TgtDo when low.
- Status  in  8  byte shifted out during the command byte.
- RegAddr  out  ADDR_WIDTH  register address.
- RegWrData  out  8  write data.
- RegWrStrobe  out  1  one-cycle write pulse.
- RegRdStrobe  out  1  one-cycle read-request pulse.
- RegRdData  in  8  read data, valid the cycle after RegRdStrobe.
- Busy  out  1  high while the synchronised nTgtSel is low.

Behaviour:
- Reset values:
  - TgtDo=1, TgtDoEn=0, RegAddr=0, RegWrData=0, strobes=0, Busy=0.
  - State=ABORT.
- Input path: each pin passes through SYNC_STAGES flops, then one edge-detect flop. A pin event is acted on SYNC_STAGES+1 FastClk cycles after the pin changes.
- Timing requirement: SCK high and low phases are each ≥4 FastClk cycles, so the maximum SCK rate is FastClk/8.
- Mode 0 operation:
  - TgtDi is sampled on synchronised SCK rising edges, MSB first.
  - TgtDo changes on synchronised SCK falling edges.
- States:
  - ABORT: wait for synchronised nTgtSel=1, then go to IDLE. Entered from reset, including reset mid-transfer; a transfer already in progress is ignored until nCS is deasserted and reasserted.
  - IDLE: on nTgtSel falling → CMD. Bit counter=0. Status is latched into the TX shifter, TgtDoEn=1, TgtDo=Status[7].
  - CMD: shift in 8 bits; the remaining Status bits go out on falling edges. On the 8th rising edge the command is decoded:
    - bit7=1 → READ; bit7=0 → WRITE.
    - RegAddr=cmd[ADDR_WIDTH-1:0]; bits between ADDR_WIDTH and bit6 are ignored.
  - WRITE:
    - TgtDo is driven 0 throughout.
    - On each 8th rising edge: RegWrData=byte and RegWrStrobe for 1 cycle, with RegAddr holding the target address. RegAddr increments on the following cycle.
  - READ, prefetch model:
    - On entry and on every 8th rising edge: RegRdStrobe for 1 cycle.
    - The next cycle, RegRdData is loaded into a holding register and RegAddr increments.
    - At the falling edge that follows, the holding byte moves to the TX shifter and TgtDo=bit7. The remaining bits follow on subsequent falling edges.
    - Consequence: the first data byte is the register at cmd address, with no dummy byte.
    - The final prefetch, issued on the last byte before nCS rises, is a harmless discarded read.
- Address increment wraps 2^ADDR_WIDTH-1 → 0.
- nTgtSel rising, in any state:
  - → IDLE, TgtDoEn=0, TgtDo=1.
  - A partial byte (<8 bits) is discarded with no strobe.
  - RegAddr keeps its last value.
- An SCK edge detected in the same cycle as nTgtSel rising is discarded.
- nTgtSel low while SCK is high at selection: ignored until SCK has gone low (mode 0 violation). No edge is counted.
- RegWrStrobe and RegRdStrobe are never high in the same cycle.
- At most one strobe occurs per byte.

Test Plan:
- Reset with nTgtSel=0 and SCK toggling → no strobes and TgtDoEn=0 until nTgtSel goes 1 then 0; all outputs at reset values.
- Status=0xC3, command 0x05 → initiator receives 0xC3 during the command byte.
- Write data 0x11,0x22,0x33, then nCS high → RegWrStrobe ×3 at addresses 0x05/0x06/0x07 with data 0x11/0x22/0x33.
- Read command 0xFE (addr 0x7E), register model returns addr^0x5A, 3 bytes clocked → MISO bytes 0x24, 0x25, 0x5A. RegRdStrobe at 0x7E, 0x7F, 0x00, then 0x01 (discarded); wrap verified.
- Write command 0x03, then 5 bits, then nCS high → no RegWrStrobe. A following command 0x10 + byte 0xAA → a single strobe at 0x10 with 0xAA.
- SCK at FastClk/8, 4-byte write then 4-byte read-back of the same addresses → data matches exactly. Busy tracks nCS with SYNC_STAGES+1 cycles of lag.
